// File: rtl/axi_bw_decoder.sv
// AXI4 B-channel router: buffers slave write responses in a 2-entry FIFO and forwards
// each one to the master-side port named by the upper ID field. Optional: AXI_BW_DEC_ERR_CNT_EN.
module axi_bw_decoder #(
    parameter int AXI_USER_W  = 6,
    parameter int N_TARG_PORT = 7,
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_ID_IN   = 16,
    parameter int AXI_ID_OUT  = AXI_ID_IN + $clog2(N_TARG_PORT)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [AXI_ID_OUT-1:0]                  bid_i,
    input  logic [1:0]                             bresp_i,
    input  logic [AXI_USER_W-1:0]                  buser_i,
    input  logic                                   bvalid_i,
    output logic                                   bready_o,
    output logic [N_TARG_PORT-1:0][AXI_ID_OUT-1:0] bid_o,
    output logic [N_TARG_PORT-1:0][1:0]            bresp_o,
    output logic [N_TARG_PORT-1:0][AXI_USER_W-1:0] buser_o,
    output logic [N_TARG_PORT-1:0]                 bvalid_o,
    input  logic [N_TARG_PORT-1:0]                 bready_i,
`ifdef AXI_BW_DEC_ERR_CNT_EN
    input  logic                                   err_cnt_clr_i,
    output logic [7:0]                             err_cnt_o,
`endif
    output logic                                   route_err_o,
    output logic                                   empty_o
);

    localparam int         SEL_W    = (N_TARG_PORT > 1) ? $clog2(N_TARG_PORT) : 1;
    localparam logic [1:0] CNT_FULL = 2'd2;

    if (AXI_DATA_W < 1) begin : g_data_w_chk
        $error("AXI_DATA_W must be positive");
    end
    if (AXI_ID_OUT < AXI_ID_IN) begin : g_id_w_chk
        $error("AXI_ID_OUT must not be narrower than AXI_ID_IN");
    end

    logic [AXI_ID_OUT-1:0] mem_bid_q   [2];
    logic [1:0]            mem_bresp_q [2];
    logic [AXI_USER_W-1:0] mem_buser_q [2];

    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;

    logic                  push_s;
    logic                  pop_s;
    logic                  head_vld_s;
    logic                  legal_s;
    logic                  sel_rdy_s;
    logic [SEL_W-1:0]      sel_s;
    logic [AXI_ID_OUT-1:0] head_bid_s;
    logic [1:0]            head_bresp_s;
    logic [AXI_USER_W-1:0] head_buser_s;
    logic [N_TARG_PORT-1:0] bvalid_s;

    assign head_vld_s   = (count_q != 2'd0);
    assign head_bid_s   = mem_bid_q[rd_ptr_q];
    assign head_bresp_s = mem_bresp_q[rd_ptr_q];
    assign head_buser_s = mem_buser_q[rd_ptr_q];

    // With a single target there is no port field in the ID.
    if (N_TARG_PORT > 1) begin : g_sel
        assign sel_s = head_bid_s[AXI_ID_OUT-1:AXI_ID_IN];
    end else begin : g_nosel
        assign sel_s = '0;
    end

    assign legal_s = ({1'b0, sel_s} < (SEL_W+1)'(N_TARG_PORT));

    // Storage write; contents intentionally not reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_bid_q[wr_ptr_q]   <= bid_i;
            mem_bresp_q[wr_ptr_q] <= bresp_i;
            mem_buser_q[wr_ptr_q] <= buser_i;
        end
    end

    // One-hot valid toward the selected master port
    always_comb begin
        bvalid_s = '0;
        for (int p = 0; p < N_TARG_PORT; p++) begin
            if (head_vld_s && legal_s && (sel_s == SEL_W'(p))) begin
                bvalid_s[p] = 1'b1;
            end else begin
                bvalid_s[p] = 1'b0;
            end
        end
    end

    // Push/pop decision; only the selected port's ready can pop a legal entry
    always_comb begin
        sel_rdy_s = |(bready_i & bvalid_s);
        push_s    = bvalid_i & (count_q != CNT_FULL);
        if (head_vld_s) begin
            pop_s = ~legal_s | sel_rdy_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    // FIFO occupancy and pointer next state
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push_s;
        rd_ptr_d = rd_ptr_q ^ pop_s;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifdef AXI_BW_DEC_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating drop counter; clear wins over a same-cycle drop
    always_comb begin
        if (err_cnt_clr_i) begin
            err_cnt_d = 8'h00;
        end else if (head_vld_s && !legal_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'h01;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Drop counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

    // Head entry is broadcast to every master port
    always_comb begin
        for (int p = 0; p < N_TARG_PORT; p++) begin
            bid_o[p]   = head_bid_s;
            bresp_o[p] = head_bresp_s;
            buser_o[p] = head_buser_s;
        end
    end

    assign bvalid_o    = bvalid_s;
    assign route_err_o = head_vld_s & ~legal_s;
    assign bready_o    = (count_q != CNT_FULL);
    assign empty_o     = ~head_vld_s;

endmodule

// File: tb/tb_axi_bw_decoder.sv
// Directed self-checking bench for axi_bw_decoder (N_TARG_PORT=7, AXI_ID_IN=4, AXI_ID_OUT=7).
module tb_axi_bw_decoder;

    localparam int U_W = 6;
    localparam int NP  = 7;
    localparam int IDI = 4;
    localparam int IDO = 7;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [IDO-1:0]           bid_i;
    logic [1:0]               bresp_i;
    logic [U_W-1:0]           buser_i;
    logic                     bvalid_i;
    logic                     bready_o;
    logic [NP-1:0][IDO-1:0]   bid_o;
    logic [NP-1:0][1:0]       bresp_o;
    logic [NP-1:0][U_W-1:0]   buser_o;
    logic [NP-1:0]            bvalid_o;
    logic [NP-1:0]            bready_i;
    logic                     route_err_o;
    logic                     empty_o;
`ifdef AXI_BW_DEC_ERR_CNT_EN
    logic                     err_cnt_clr_i;
    logic [7:0]               err_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    axi_bw_decoder #(
        .AXI_USER_W (U_W),
        .N_TARG_PORT(NP),
        .AXI_DATA_W (64),
        .AXI_ID_IN  (IDI),
        .AXI_ID_OUT (IDO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bid_i      (bid_i),
        .bresp_i    (bresp_i),
        .buser_i    (buser_i),
        .bvalid_i   (bvalid_i),
        .bready_o   (bready_o),
        .bid_o      (bid_o),
        .bresp_o    (bresp_o),
        .buser_o    (buser_o),
        .bvalid_o   (bvalid_o),
        .bready_i   (bready_i),
`ifdef AXI_BW_DEC_ERR_CNT_EN
        .err_cnt_clr_i(err_cnt_clr_i),
        .err_cnt_o  (err_cnt_o),
`endif
        .route_err_o(route_err_o),
        .empty_o    (empty_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic [IDO-1:0] prev_bid;
        logic [NP-1:0]  prev_vld;

        rst_n    = 1'b0;
        bid_i    = '0;
        bresp_i  = 2'b00;
        buser_i  = '0;
        bvalid_i = 1'b0;
        bready_i = '0;
`ifdef AXI_BW_DEC_ERR_CNT_EN
        err_cnt_clr_i = 1'b0;
`endif
        repeat (3) tick();
        check_val("rst_bready", 32'(bready_o), 32'd1);
        check_val("rst_empty", 32'(empty_o), 32'd1);
        check_val("rst_bvalid", 32'(bvalid_o), 32'd0);
        check_val("rst_rerr", 32'(route_err_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic routing: sel = 2
        bid_i    = 7'h25;
        bresp_i  = 2'b00;
        buser_i  = 6'h11;
        bvalid_i = 1'b1;
        bready_i = 7'h7F;
        tick();
        bvalid_i = 1'b0;
        check_val("basic_bvalid", 32'(bvalid_o), 32'h04);
        check_val("basic_bid0", 32'(bid_o[0]), 32'h25);
        check_val("basic_bid6", 32'(bid_o[6]), 32'h25);
        check_val("basic_buser3", 32'(buser_o[3]), 32'h11);
        check_val("basic_bresp2", 32'(bresp_o[2]), 32'h0);
        check_val("basic_nempty", 32'(empty_o), 32'd0);
        tick();
        check_val("basic_empty", 32'(empty_o), 32'd1);
        check_val("basic_drained", 32'(bvalid_o), 32'd0);

        // Back-pressure: A->port1, B->port3, C->port1
        bready_i = 7'h00;
        bid_i    = 7'h1A;
        bresp_i  = 2'b01;
        bvalid_i = 1'b1;
        tick();
        check_val("bp_rdy1", 32'(bready_o), 32'd1);
        bid_i   = 7'h3B;
        bresp_i = 2'b10;
        tick();
        check_val("bp_full", 32'(bready_o), 32'd0);
        bid_i   = 7'h1C;
        bresp_i = 2'b11;
        tick();
        check_val("bp_hold", 32'(bready_o), 32'd0);
        check_val("bp_vldA", 32'(bvalid_o), 32'h02);
        check_val("bp_bidA", 32'(bid_o[1]), 32'h1A);
        bready_i = 7'b0001000;
        tick();
        check_val("bp_ignore_vld", 32'(bvalid_o), 32'h02);
        check_val("bp_ignore_bid", 32'(bid_o[1]), 32'h1A);
        check_val("bp_ignore_resp", 32'(bresp_o[1]), 32'h1);
        bready_i = 7'b0000010;
        tick();
        check_val("bp_vldB", 32'(bvalid_o), 32'h08);
        check_val("bp_bidB", 32'(bid_o[3]), 32'h3B);
        check_val("bp_room", 32'(bready_o), 32'd1);
        tick();
        bvalid_i = 1'b0;
        check_val("bp_B_stable", 32'(bvalid_o), 32'h08);
        check_val("bp_B_bid", 32'(bid_o[3]), 32'h3B);
        check_val("bp_full2", 32'(bready_o), 32'd0);
        bready_i = 7'b0001000;
        tick();
        check_val("bp_vldC", 32'(bvalid_o), 32'h02);
        check_val("bp_bidC", 32'(bid_o[1]), 32'h1C);
        check_val("bp_respC", 32'(bresp_o[1]), 32'h3);
        bready_i = 7'b0000010;
        tick();
        check_val("bp_empty", 32'(empty_o), 32'd1);

        // Illegal route: sel = 7
        bready_i = 7'h00;
        bid_i    = 7'h70;
        bvalid_i = 1'b1;
        tick();
        bvalid_i = 1'b0;
        check_val("ill_novld", 32'(bvalid_o), 32'd0);
        check_val("ill_rerr", 32'(route_err_o), 32'd1);
        check_val("ill_nempty", 32'(empty_o), 32'd0);
        tick();
        check_val("ill_rerr_end", 32'(route_err_o), 32'd0);
        check_val("ill_empty", 32'(empty_o), 32'd1);
`ifdef AXI_BW_DEC_ERR_CNT_EN
        check_val("ill_cnt", 32'(err_cnt_o), 32'd1);
`endif

        // Illegal entry followed by a legal one for port 6
        bid_i    = 7'h70;
        bvalid_i = 1'b1;
        tick();
        bid_i = 7'h65;
        check_val("mix_rerr", 32'(route_err_o), 32'd1);
        tick();
        bvalid_i = 1'b0;
        check_val("mix_rerr_off", 32'(route_err_o), 32'd0);
        check_val("mix_vld6", 32'(bvalid_o), 32'h40);
        check_val("mix_bid6", 32'(bid_o[6]), 32'h65);
        bready_i = 7'h40;
        tick();
        check_val("mix_empty", 32'(empty_o), 32'd1);

        // Streaming: one response per cycle to ports 0..5
        bready_i = 7'h7F;
        prev_bid = '0;
        prev_vld = '0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                check_val("str_vld", 32'(bvalid_o), 32'(prev_vld));
                check_val("str_bid", 32'(bid_o[0]), 32'(prev_bid));
            end
            check_val("str_rdy", 32'(bready_o), 32'd1);
            bid_i    = {3'(i), 4'(i + 1)};
            bvalid_i = 1'b1;
            prev_bid = {3'(i), 4'(i + 1)};
            prev_vld = 7'(1 << i);
            tick();
        end
        bvalid_i = 1'b0;
        check_val("str_last_vld", 32'(bvalid_o), 32'h20);
        check_val("str_last_bid", 32'(bid_o[5]), 32'h56);
        tick();
        check_val("str_empty", 32'(empty_o), 32'd1);

        // Reset with two entries buffered
        bready_i = 7'h00;
        bid_i    = 7'h41;
        bvalid_i = 1'b1;
        tick();
        bid_i = 7'h52;
        tick();
        bvalid_i = 1'b0;
        check_val("rstm_full", 32'(bready_o), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_val("rstm_vld", 32'(bvalid_o), 32'd0);
        check_val("rstm_empty", 32'(empty_o), 32'd1);
        check_val("rstm_rdy", 32'(bready_o), 32'd1);
        bready_i = 7'h7F;
        tick();
        check_val("rstm_nostale", 32'(bvalid_o), 32'd0);
        check_val("rstm_empty2", 32'(empty_o), 32'd1);

`ifdef AXI_BW_DEC_ERR_CNT_EN
        // Counter saturation and clear priority
        bid_i    = 7'h70;
        bvalid_i = 1'b1;
        repeat (260) tick();
        bvalid_i = 1'b0;
        tick();
        check_val("cnt_sat", 32'(err_cnt_o), 32'hFF);
        bvalid_i = 1'b1;
        tick();
        bvalid_i      = 1'b0;
        err_cnt_clr_i = 1'b1;
        check_val("cnt_clr_rerr", 32'(route_err_o), 32'd1);
        tick();
        err_cnt_clr_i = 1'b0;
        check_val("cnt_clr", 32'(err_cnt_o), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
